// File: rtl/msi_cpu_request_frontend_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : msi_pkg
// Purpose  : MSI state / bus message encodings and the front-end FSM type.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package msi_pkg;

   localparam logic [1:0] MSI_I = 2'b00;
   localparam logic [1:0] MSI_S = 2'b01;
   localparam logic [1:0] MSI_M = 2'b10;

   localparam logic [1:0] BUS_NONE       = 2'b00;
   localparam logic [1:0] BUS_READ_MISS  = 2'b01;
   localparam logic [1:0] BUS_WRITE_MISS = 2'b10;
   localparam logic [1:0] BUS_INVALIDATE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOOKUP   = 3'd1,
      ST_APPLY    = 3'd2,
      ST_BUS_WAIT = 3'd3,
      ST_DONE     = 3'd4
   } main_state_t;

   // The unused code 2'b11 behaves exactly like Invalid.
   function automatic logic [1:0] msi_norm(input logic [1:0] st);
      return (st == 2'b11) ? MSI_I : st;
   endfunction

endpackage
`default_nettype wire

// File: rtl/msi_cpu_request_frontend_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : msi_cpu_request_frontend_if
// Purpose  : CPU, controller, bus and snoop signals of the request front end.
//            slave = front-end view, master = surrounding-system view.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface msi_cpu_request_frontend_if #(
   parameter int ADDR_W  = 8,
   parameter int INDEX_W = 2
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic              req_done;
   logic              req_hit;

   logic [1:0]        fsm_state;
   logic              fsm_read_hit;
   logic              fsm_read_miss;
   logic              fsm_write_hit;
   logic              fsm_write_miss;
   logic [1:0]        fsm_state_out;
   logic [1:0]        fsm_bus_out;
   logic              fsm_write_back;

   logic              bus_valid;
   logic              bus_ready;
   logic [1:0]        bus_msg;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wb;
   logic [ADDR_W-1:0] bus_wb_addr;

   logic               snoop_valid;
   logic [INDEX_W-1:0] snoop_index;
   logic [1:0]         snoop_state;

   modport slave (
      input  req_valid, req_write, req_addr,
      output req_ready, req_done, req_hit,
      output fsm_state, fsm_read_hit, fsm_read_miss, fsm_write_hit, fsm_write_miss,
      input  fsm_state_out, fsm_bus_out, fsm_write_back,
      output bus_valid, bus_msg, bus_addr, bus_wb, bus_wb_addr,
      input  bus_ready,
      input  snoop_valid, snoop_index, snoop_state
   );

   modport master (
      output req_valid, req_write, req_addr,
      input  req_ready, req_done, req_hit,
      input  fsm_state, fsm_read_hit, fsm_read_miss, fsm_write_hit, fsm_write_miss,
      output fsm_state_out, fsm_bus_out, fsm_write_back,
      input  bus_valid, bus_msg, bus_addr, bus_wb, bus_wb_addr,
      output bus_ready,
      output snoop_valid, snoop_index, snoop_state
   );
endinterface
`default_nettype wire

// File: rtl/msi_cpu_request_frontend_line_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : msi_line_array
// Purpose  : Tag + MSI state storage, one CPU write port, one snoop write
//            port (state only), asynchronous read port.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module msi_line_array #(
   parameter int INDEX_W = 2,
   parameter int TAG_W   = 6
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               i_cpu_we,
   input  wire logic [INDEX_W-1:0] i_cpu_idx,
   input  wire logic [TAG_W-1:0]   i_cpu_tag,
   input  wire logic [1:0]         i_cpu_state,
   input  wire logic               i_snp_we,
   input  wire logic [INDEX_W-1:0] i_snp_idx,
   input  wire logic [1:0]         i_snp_state,
   input  wire logic [INDEX_W-1:0] i_rd_idx,
   output logic      [TAG_W-1:0]   o_rd_tag,
   output logic      [1:0]         o_rd_state
);
   localparam int NUM_LINES = 2**INDEX_W;

   logic [TAG_W-1:0] r_tag   [NUM_LINES];
   logic [1:0]       r_state [NUM_LINES];

   // Line storage; snoop is written last so it wins any same-index collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            r_tag[i]   <= '0;
            r_state[i] <= 2'b00;
         end
      end else begin
         if (i_cpu_we) begin
            r_tag[i_cpu_idx]   <= i_cpu_tag;
            r_state[i_cpu_idx] <= i_cpu_state;
         end
         if (i_snp_we) begin
            r_state[i_snp_idx] <= i_snp_state;
         end
      end
   end

   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_state = r_state[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/msi_cpu_request_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : msi_cpu_request_frontend
// Purpose  : Classifies CPU accesses against a direct-mapped tag/MSI array,
//            hands them to the MSI controller, commits its result and issues
//            the resulting bus transaction.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module msi_cpu_request_frontend
   import msi_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int INDEX_W = 2,
   parameter int TAG_W   = ADDR_W - INDEX_W
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   msi_cpu_request_frontend_if.slave  bif
);
   main_state_t        r_state;
   main_state_t        w_next;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_write;
   logic               r_hit;
   logic [1:0]         r_bus_msg;
   logic               r_bus_wb;
   logic [ADDR_W-1:0]  r_bus_wb_addr;

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [TAG_W-1:0]   w_line_tag;
   logic [1:0]         w_line_raw;
   logic [1:0]         w_line_state;
   logic               w_hit;
   logic               w_classify;
   logic               w_snoop_hit;
   logic               w_commit;
   logic [1:0]         w_sel;

   assign w_idx        = r_addr[INDEX_W-1:0];
   assign w_tag        = r_addr[ADDR_W-1:INDEX_W];
   assign w_line_state = msi_norm(w_line_raw);
   assign w_hit        = (w_line_state != MSI_I) && (w_line_tag == w_tag);
   assign w_classify   = (r_state == ST_LOOKUP) || (r_state == ST_APPLY);
   // A snoop touching the line being classified invalidates the lookup.
   assign w_snoop_hit  = bif.snoop_valid && (bif.snoop_index == w_idx) && w_classify;
   assign w_commit     = (r_state == ST_APPLY) && !w_snoop_hit;
   assign w_sel        = {r_write, w_hit};

   msi_line_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_lines (
      .clk         (clk),
      .rst         (rst),
      .i_cpu_we    (w_commit),
      .i_cpu_idx   (w_idx),
      .i_cpu_tag   (w_tag),
      .i_cpu_state (msi_norm(bif.fsm_state_out)),
      .i_snp_we    (bif.snoop_valid),
      .i_snp_idx   (bif.snoop_index),
      .i_snp_state (bif.snoop_state),
      .i_rd_idx    (w_idx),
      .o_rd_tag    (w_line_tag),
      .o_rd_state  (w_line_raw)
   );

   // Main FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (bif.req_valid) w_next = ST_LOOKUP;
         ST_LOOKUP:   w_next = w_snoop_hit ? ST_LOOKUP : ST_APPLY;
         ST_APPLY: begin
            if (w_snoop_hit)                       w_next = ST_LOOKUP;
            else if (bif.fsm_bus_out == BUS_NONE)  w_next = ST_DONE;
            else                                   w_next = ST_BUS_WAIT;
         end
         ST_BUS_WAIT: if (bif.bus_ready) w_next = ST_DONE;
         ST_DONE:     w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   // Request capture and commit-time capture of the bus transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr        <= '0;
         r_write       <= 1'b0;
         r_hit         <= 1'b0;
         r_bus_msg     <= BUS_NONE;
         r_bus_wb      <= 1'b0;
         r_bus_wb_addr <= '0;
      end else begin
         if ((r_state == ST_IDLE) && bif.req_valid) begin
            r_addr  <= bif.req_addr;
            r_write <= bif.req_write;
         end
         if (w_commit) begin
            r_hit         <= w_hit;
            r_bus_msg     <= bif.fsm_bus_out;
            r_bus_wb      <= bif.fsm_write_back;
            r_bus_wb_addr <= {w_line_tag, w_idx};
         end
      end
   end

   assign bif.req_ready      = (r_state == ST_IDLE);
   assign bif.req_done       = (r_state == ST_DONE);
   assign bif.req_hit        = (r_state == ST_DONE) && r_hit;
   assign bif.fsm_state      = w_classify ? w_line_state : MSI_I;
   assign bif.fsm_read_miss  = w_classify && (w_sel == 2'b00);
   assign bif.fsm_read_hit   = w_classify && (w_sel == 2'b01);
   assign bif.fsm_write_miss = w_classify && (w_sel == 2'b10);
   assign bif.fsm_write_hit  = w_classify && (w_sel == 2'b11);
   assign bif.bus_valid      = (r_state == ST_BUS_WAIT);
   assign bif.bus_msg        = r_bus_msg;
   assign bif.bus_addr       = r_addr;
   assign bif.bus_wb         = r_bus_wb;
   assign bif.bus_wb_addr    = r_bus_wb_addr;

endmodule
`default_nettype wire

// File: tb/tb_msi_cpu_request_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_msi_cpu_request_frontend
// Purpose  : Directed self-checking bench; expected completions are queued
//            when a request is issued and compared when req_done appears.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_msi_cpu_request_frontend;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic sb_hit[$];

   localparam logic [3:0] OH_RH = 4'b1000;
   localparam logic [3:0] OH_RM = 4'b0100;
   localparam logic [3:0] OH_WH = 4'b0010;
   localparam logic [3:0] OH_WM = 4'b0001;
   localparam logic [3:0] OH_NONE = 4'b0000;

   msi_cpu_request_frontend_if #(.ADDR_W(8), .INDEX_W(2)) bif ();

   msi_cpu_request_frontend #(.ADDR_W(8), .INDEX_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh();
      return {bif.fsm_read_hit, bif.fsm_read_miss, bif.fsm_write_hit, bif.fsm_write_miss};
   endfunction

   task automatic pop_done(input string tag);
      logic e;
      if (sb_hit.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_hit.pop_front();
         chk({tag, "_req_hit"}, bif.req_hit, e);
      end
   endtask

   // Full request: issue, check classification, act as controller, check bus
   // transaction, wait for completion and check latency.
   task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [1:0] c_st, input logic [1:0] c_bus, input logic c_wb,
                         input logic [3:0] e_oh, input logic [1:0] e_fst, input logic e_hit,
                         input logic [7:0] e_wba, input int bus_delay);
      int  cyc;
      int  nb;
      bit  done;
      int  e_lat;
      sb_hit.push_back(e_hit);
      e_lat = (c_bus == 2'b00) ? 3 : 4 + bus_delay;
      bif.fsm_state_out  = c_st;
      bif.fsm_bus_out    = c_bus;
      bif.fsm_write_back = c_wb;
      bif.req_write      = wr;
      bif.req_addr       = addr;
      bif.req_valid      = 1'b1;
      step();
      bif.req_valid = 1'b0;
      chk({tag, "_ready_low"}, bif.req_ready, 1'b0);
      chk({tag, "_onehot_lookup"}, oh(), e_oh);
      chk({tag, "_fsm_state"}, bif.fsm_state, e_fst);
      step();
      chk({tag, "_onehot_apply"}, oh(), e_oh);
      cyc  = 2;
      nb   = 0;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         step();
         cyc++;
         if (cyc == 3) begin
            chk({tag, "_bus_valid_c3"}, bif.bus_valid, (c_bus != 2'b00));
            chk({tag, "_onehot_after"}, oh(), OH_NONE);
         end
         if (bif.bus_valid) begin
            if (nb == 0) begin
               chk({tag, "_bus_msg"}, bif.bus_msg, c_bus);
               chk({tag, "_bus_addr"}, bif.bus_addr, addr);
               chk({tag, "_bus_wb"}, bif.bus_wb, c_wb);
               if (c_wb) chk({tag, "_bus_wb_addr"}, bif.bus_wb_addr, e_wba);
            end
            bif.bus_ready = (nb >= bus_delay);
            nb++;
         end
         if (bif.req_done) begin
            pop_done(tag);
            chk({tag, "_latency"}, cyc, e_lat);
            done = 1;
         end
      end
      if (!done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      bif.bus_ready = 1'b0;
      step();
      chk({tag, "_done_one_cycle"}, bif.req_done, 1'b0);
   endtask

   initial begin
      bif.req_valid = 0; bif.req_write = 0; bif.req_addr = '0;
      bif.fsm_state_out = 0; bif.fsm_bus_out = 0; bif.fsm_write_back = 0;
      bif.bus_ready = 0; bif.snoop_valid = 0; bif.snoop_index = '0; bif.snoop_state = '0;

      step();
      step();
      chk("rst_ready", bif.req_ready, 1'b1);
      chk("rst_done", bif.req_done, 1'b0);
      chk("rst_bus_valid", bif.bus_valid, 1'b0);
      chk("rst_onehot", oh(), OH_NONE);
      chk("rst_fsm_state", bif.fsm_state, 2'b00);
      rst = 1'b0;
      step();

      //        tag   wr addr   ctl_st ctl_bus wb  onehot fst   hit wb_addr delay
      do_req("rd_miss", 0, 8'h14, 2'b01, 2'b01, 0, OH_RM, 2'b00, 0, 8'h00, 2);
      do_req("rd_hit",  0, 8'h14, 2'b01, 2'b00, 0, OH_RH, 2'b01, 1, 8'h00, 0);
      do_req("wr_hit",  1, 8'h14, 2'b10, 2'b11, 0, OH_WH, 2'b01, 1, 8'h00, 0);
      do_req("evict",   0, 8'h24, 2'b01, 2'b01, 1, OH_RM, 2'b10, 0, 8'h14, 1);
      do_req("rd_new",  0, 8'h24, 2'b01, 2'b00, 0, OH_RH, 2'b01, 1, 8'h00, 0);
      do_req("fill1",   0, 8'h15, 2'b01, 2'b01, 0, OH_RM, 2'b00, 0, 8'h00, 0);

      // Snoop invalidates line 1 while a write to it sits in APPLY.
      sb_hit.push_back(1'b0);
      bif.fsm_state_out = 2'b10; bif.fsm_bus_out = 2'b11; bif.fsm_write_back = 0;
      bif.req_write = 1; bif.req_addr = 8'h15; bif.req_valid = 1;
      step();
      bif.req_valid = 0;
      chk("snp_onehot_pre", oh(), OH_WH);
      step();
      chk("snp_in_apply", oh(), OH_WH);
      bif.snoop_valid = 1; bif.snoop_index = 2'd1; bif.snoop_state = 2'b00;
      step();
      bif.snoop_valid = 0;
      chk("snp_relookup_onehot", oh(), OH_WM);
      chk("snp_relookup_fst", bif.fsm_state, 2'b00);
      chk("snp_no_bus", bif.bus_valid, 1'b0);
      chk("snp_no_done", bif.req_done, 1'b0);
      bif.fsm_bus_out = 2'b10;
      step();
      chk("snp_apply_again", oh(), OH_WM);
      step();
      chk("snp_bus_valid", bif.bus_valid, 1'b1);
      chk("snp_bus_msg", bif.bus_msg, 2'b10);
      bif.bus_ready = 1;
      step();
      bif.bus_ready = 0;
      chk("snp_done", bif.req_done, 1'b1);
      if (bif.req_done) pop_done("snp");
      step();

      // Reset while a transaction waits on the bus.
      bif.fsm_state_out = 2'b01; bif.fsm_bus_out = 2'b01; bif.fsm_write_back = 0;
      bif.req_write = 0; bif.req_addr = 8'h38; bif.req_valid = 1;
      step();
      bif.req_valid = 0;
      step();
      step();
      chk("mid_rst_bus_wait", bif.bus_valid, 1'b1);
      rst = 1;
      step();
      chk("mid_rst_bus_valid", bif.bus_valid, 1'b0);
      chk("mid_rst_ready", bif.req_ready, 1'b1);
      chk("mid_rst_done", bif.req_done, 1'b0);
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("post_rst_no_done", bif.req_done, 1'b0);
         chk("post_rst_no_bus", bif.bus_valid, 1'b0);
      end
      do_req("post_rst_l0", 0, 8'h24, 2'b00, 2'b00, 0, OH_RM, 2'b00, 0, 8'h00, 0);
      do_req("post_rst_l1", 0, 8'h15, 2'b00, 2'b00, 0, OH_RM, 2'b00, 0, 8'h00, 0);

      chk("sb_drained", sb_hit.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
